alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 34 +++
 rtl/alu_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Request/response and external-ALU signal bundle for alu_sequencer.
// master = requester plus the combinational ALU; slave = the sequencer.
interface alu_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [3:0]  alu_control;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_branch_taken;
   logic        rsp_error;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output req_valid, opcode, funct, operand_a, operand_b, alu_result, alu_zero, rsp_ready,
      input  req_ready, alu_control, alu_a, alu_b, rsp_valid, rsp_data, rsp_branch_taken,
             rsp_error, hi, lo
   );

   modport slave (
      input  req_valid, opcode, funct, operand_a, operand_b, alu_result, alu_zero, rsp_ready,
      output req_ready, alu_control, alu_a, alu_b, rsp_valid, rsp_data, rsp_branch_taken,
             rsp_error, hi, lo
   );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences MIPS add/sub/slt/beq/bne/addi (plus shift-add multu when ALU_SEQ_MULT_EN is defined) onto an
// external ALU; one op in flight, response consumable 2 edges after accept (multu 34), held until rsp_ready.
module alu_sequencer (
   input  logic           clock,
   input  logic           reset_n,
   alu_sequencer_if.slave bus
);

   localparam logic [3:0] CTL_NONE = 4'b0000;
   localparam logic [3:0] CTL_ADD  = 4'b0010;
   localparam logic [3:0] CTL_SUB  = 4'b0110;
   localparam logic [3:0] CTL_SLT  = 4'b0111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

`ifdef ALU_SEQ_MULT_EN
   typedef enum logic [1:0] {IDLE, EXEC, MULT, RESP} state_t;
`else
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

   state_t      state_q, state_d;
   logic        armed_q;
   logic [5:0]  opcode_q;
   logic [5:0]  funct_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] rsp_data_q;
   logic        rsp_taken_q;
   logic        rsp_error_q;
   logic [3:0]  exec_ctl;
   logic        accept;

   function automatic logic [3:0] decode(input logic [5:0] op, input logic [5:0] fn);
      logic [3:0] ctl;
      ctl = CTL_NONE;
      case (op)
         OP_RTYPE: begin
            case (fn)
               6'b100000, 6'b100001: ctl = CTL_ADD;
               6'b100010, 6'b100011: ctl = CTL_SUB;
               6'b101010:            ctl = CTL_SLT;
               default:              ctl = CTL_NONE;
            endcase
         end
         OP_BEQ, OP_BNE: ctl = CTL_SUB;
         OP_ADDI:        ctl = CTL_ADD;
         default:        ctl = CTL_NONE;
      endcase
      return ctl;
   endfunction

   assign exec_ctl = decode(opcode_q, funct_q);
   // armed_q keeps req_ready low until the first edge after reset release
   assign accept   = (state_q == IDLE) && armed_q && bus.req_valid;

`ifdef ALU_SEQ_MULT_EN
   localparam logic [5:0] FN_MULTU = 6'b011001;

   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [5:0]  step_q;
   logic        is_multu;
   logic        carry;

   assign is_multu = (bus.opcode == OP_RTYPE) && (bus.funct == FN_MULTU);
   assign carry    = bus.alu_result < hi_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   // lo holds the multiplier and shifts out one bit per step; b_q is the multiplicand
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         step_q <= '0;
      end else if (accept && is_multu) begin
         hi_q   <= '0;
         lo_q   <= bus.operand_a;
         step_q <= '0;
      end else if ((state_q == MULT) && (step_q != 6'd32)) begin
         {hi_q, lo_q} <= {carry, bus.alu_result, lo_q[31:1]};
         step_q       <= step_q + 6'd1;
      end
   end
`else
   assign bus.hi = '0;
   assign bus.lo = '0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      bus.req_ready   = 1'b0;
      bus.rsp_valid   = 1'b0;
      bus.alu_control = CTL_NONE;
      bus.alu_a       = '0;
      bus.alu_b       = '0;
      case (state_q)
         IDLE: begin
            bus.req_ready = armed_q;
            if (accept) begin
               state_d = EXEC;
`ifdef ALU_SEQ_MULT_EN
               if (is_multu) state_d = MULT;
`endif
            end
         end
         EXEC: begin
            bus.alu_control = exec_ctl;
            bus.alu_a       = a_q;
            bus.alu_b       = b_q;
            state_d         = RESP;
         end
`ifdef ALU_SEQ_MULT_EN
         MULT: begin
            bus.alu_control = CTL_ADD;
            bus.alu_a       = hi_q;
            bus.alu_b       = lo_q[0] ? b_q : '0;
            if (step_q == 6'd32) state_d = RESP;
         end
`endif
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         armed_q     <= 1'b0;
         opcode_q    <= '0;
         funct_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rsp_data_q  <= '0;
         rsp_taken_q <= 1'b0;
         rsp_error_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         if (accept) begin
            opcode_q <= bus.opcode;
            funct_q  <= bus.funct;
            a_q      <= bus.operand_a;
            b_q      <= bus.operand_b;
         end
         if (state_q == EXEC) begin
            rsp_data_q  <= (exec_ctl == CTL_NONE) ? '0 : bus.alu_result;
            rsp_taken_q <= (opcode_q == OP_BEQ) ? bus.alu_zero :
                           (opcode_q == OP_BNE) ? ~bus.alu_zero : 1'b0;
            rsp_error_q <= (exec_ctl == CTL_NONE);
         end
`ifdef ALU_SEQ_MULT_EN
         if ((state_q == MULT) && (step_q == 6'd32)) begin
            rsp_data_q  <= lo_q;
            rsp_taken_q <= 1'b0;
            rsp_error_q <= 1'b0;
         end
`endif
      end
   end

   assign bus.rsp_data         = rsp_data_q;
   assign bus.rsp_branch_taken = rsp_taken_q;
   assign bus.rsp_error        = rsp_error_q;

endmodule
